// File: rtl/ads1672_acq_sequencer.sv
// Acquisition sequencer for the ADS1672 serial port: start pulse, DRDY wait with timeout,
// SCLK generation, 24-bit MSB-first capture, and a single-entry valid/ready output register.
module ads1672_acq_sequencer #(
    parameter int DATA_WIDTH     = 24,
    parameter int SCLK_DIV       = 4,
    parameter int START_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  start,
    input  logic                  drdy_n,
    output logic                  sclk,
    input  logic                  dout,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic [15:0]           drop_count,
    output logic                  timeout,
    output logic                  busy
);

    localparam int PHASE_MAX = (START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(PHASE_MAX + 1);
    localparam int DIV_W     = $clog2(SCLK_DIV + 1);
    localparam int BIT_W     = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_SHIFT,
        S_DELIVER
    } state_t;

    state_t                  state_q;
    logic                    start_q;
    logic                    sclk_q;
    logic                    busy_q;
    logic                    timeout_q;
    logic [CNT_W-1:0]        phase_cnt_q;
    logic [DIV_W-1:0]        div_cnt_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   sample_data_q;
    logic                    sample_valid_q;
    logic [15:0]             drop_count_q;
    logic [15:0]             drop_count_d;

    logic                    sync1_q;
    logic                    sync2_q;
    logic                    sync_prev_q;
    logic                    fall_q;

    logic                    spurious_fall;
    logic                    discard_word;
    logic [1:0]              drop_inc;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // DRDY synchronizer; the falling-edge detect is registered, so SHIFT starts 3 edges after sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_prev_q <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            sync1_q     <= drdy_n;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            fall_q      <= sync_prev_q & ~sync2_q;
        end
    end

    // A fall and a discarded word can coincide in DELIVER, hence an increment of up to two.
    always_comb begin
        spurious_fall = fall_q && (state_q != S_WAIT);
        discard_word  = (state_q == S_DELIVER) && sample_valid_q && !sample_ready;
        drop_inc      = {1'b0, spurious_fall} + {1'b0, discard_word};
        drop_count_d  = sat_add16(drop_count_q, drop_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= 16'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b0;
            sclk_q         <= 1'b0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
            phase_cnt_q    <= '0;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (sample_valid_q && sample_ready) begin
                sample_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q     <= S_START;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        phase_cnt_q <= '0;
                    end
                end

                S_START: begin
                    if (phase_cnt_q == START_LAST) begin
                        state_q     <= S_WAIT;
                        start_q     <= 1'b0;
                        phase_cnt_q <= '0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    if (fall_q) begin
                        state_q   <= S_SHIFT;
                        sclk_q    <= 1'b1;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end else if (!enable) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (phase_cnt_q == TMO_LAST) begin
                        state_q     <= S_START;
                        start_q     <= 1'b1;
                        timeout_q   <= 1'b1;
                        phase_cnt_q <= '0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + CNT_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                        // The ADC updates dout on the rising edge, so it is captured on the falling one.
                        if (sclk_q) begin
                            shift_q <= {shift_q[DATA_WIDTH-2:0], dout};
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= S_DELIVER;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end

                S_DELIVER: begin
                    if (!sample_valid_q || sample_ready) begin
                        sample_data_q  <= shift_q;
                        sample_valid_q <= 1'b1;
                    end
                    if (enable) begin
                        state_q     <= S_WAIT;
                        phase_cnt_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    start_q <= 1'b0;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start        = start_q;
    assign sclk         = sclk_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign drop_count   = drop_count_q;

endmodule
